// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and shifts it out one bit per shift_en step, with gapless back-to-back reload.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pdata_in,
  input  logic             pvalid,
  output logic             pready,
  input  logic             shift_en,
  output logic             dout,
  output logic             dvalid,
  output logic             dlast,
  output logic             busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last;

  assign last = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    pready  = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          pready = 1'b1;
          if (pvalid) begin
            sr_d    = pdata_in;
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (!last) begin
              // Zero fill; fill bits are never seen because the word ends first.
              sr_d  = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
              cnt_d = cnt_q + 1'b1;
            end else begin
              pready = 1'b1;
              cnt_d  = '0;
              if (pvalid) begin
                sr_d = pdata_in;
              end else begin
                sr_d    = '0;
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Serial outputs come from registered state only.
  assign busy   = (state_q == SHIFT);
  assign dvalid = busy;
  assign dlast  = busy && last;
  assign dout   = busy && (LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1]);

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: LSB-first and MSB-first instances, back-to-back,
// pacing, reset mid-word and loopback into a 4-stage receiver shift register.
module tb_piso_tx;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pdata [2];
  logic [1:0] pvalid, shift_en;
  logic [1:0] pready, dout, dvalid, dlast, busy;
  logic [3:0] rx_q;
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .pdata_in(pdata[0]), .pvalid(pvalid[0]), .pready(pready[0]),
    .shift_en(shift_en[0]), .dout(dout[0]), .dvalid(dvalid[0]), .dlast(dlast[0]), .busy(busy[0]));

  piso_tx #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .pdata_in(pdata[1]), .pvalid(pvalid[1]), .pready(pready[1]),
    .shift_en(shift_en[1]), .dout(dout[1]), .dvalid(dvalid[1]), .dlast(dlast[1]), .busy(busy[1]));

  // Receiver end of the link: 4-stage serial shift register fed by the LSB-first dout.
  always_ff @(posedge clk) begin
    if (reset) rx_q <= '0;
    else       rx_q <= {rx_q[2:0], dout[0]};
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Send one word on instance s with shift_en=1; exp[i] is the i-th bit on the wire.
  task automatic send(input int s, input logic [3:0] w, input logic [3:0] exp, input string tag);
    pvalid[s] = 1'b1; pdata[s] = w; shift_en[s] = 1'b1;
    @(negedge clk);
    chk({tag, " pready before accept"}, pready[s], 1'b1);
    nxt();
    pvalid[s] = 1'b0; pdata[s] = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("%s dout[%0d]", tag, i), dout[s], exp[i]);
      chk($sformatf("%s dvalid[%0d]", tag, i), dvalid[s], 1'b1);
      chk($sformatf("%s dlast[%0d]", tag, i), dlast[s], i == 3);
      chk($sformatf("%s pready[%0d]", tag, i), pready[s], i == 3);
      nxt();
    end
    @(negedge clk);
    chk({tag, " idle dvalid"}, dvalid[s], 1'b0);
    chk({tag, " idle pready"}, pready[s], 1'b1);
    chk({tag, " idle dout"}, dout[s], 1'b0);
    nxt();
  endtask

  initial begin
    logic [7:0] b2b_exp;
    logic [3:0] pace_exp;
    logic [3:0] loop_exp;
    b2b_exp  = 8'b1001_0110;  // bits in wire order: 0,1,1,0,1,0,0,1
    pace_exp = 4'b1100;       // 0,0,1,1
    loop_exp = 4'b1011;       // 1,1,0,1

    reset = 1'b1; pvalid = '0; shift_en = '0; pdata[0] = 4'h0; pdata[1] = 4'h0;
    repeat (2) nxt();
    // Offer a word while reset is high: must be refused.
    pvalid[0] = 1'b1; pdata[0] = 4'hF; shift_en[0] = 1'b1;
    @(negedge clk);
    chk("reset pready", pready[0], 1'b0);
    chk("reset dvalid", dvalid[0], 1'b0);
    chk("reset dout", dout[0], 1'b0);
    chk("reset dlast", dlast[0], 1'b0);
    chk("reset busy", busy[0], 1'b0);
    nxt();
    reset = 1'b0; pvalid[0] = 1'b0;
    @(negedge clk);
    chk("post-reset busy", busy[0], 1'b0);
    chk("post-reset pready", pready[0], 1'b1);
    chk("post-reset msb pready", pready[1], 1'b1);
    nxt();

    send(0, 4'b1011, 4'b1011, "lsb single");
    send(1, 4'b1011, 4'b1101, "msb single");

    // Back-to-back with pvalid held high.
    pvalid[0] = 1'b1; pdata[0] = 4'b0110; shift_en[0] = 1'b1;
    @(negedge clk);
    chk("b2b pready idle", pready[0], 1'b1);
    nxt();
    pdata[0] = 4'b1001;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b dout[%0d]", i), dout[0], b2b_exp[i]);
      chk($sformatf("b2b dvalid[%0d]", i), dvalid[0], 1'b1);
      chk($sformatf("b2b dlast[%0d]", i), dlast[0], (i == 3) || (i == 7));
      chk($sformatf("b2b pready[%0d]", i), pready[0], (i == 3) || (i == 7));
      nxt();
      if (i == 3) begin pvalid[0] = 1'b0; pdata[0] = 4'h0; end
    end
    @(negedge clk);
    chk("b2b end dvalid", dvalid[0], 1'b0);
    nxt();

    // Pacing: shift_en every 3rd cycle; shift_en at accept in IDLE is irrelevant.
    pvalid[0] = 1'b1; pdata[0] = 4'b1100; shift_en[0] = 1'b0;
    nxt();
    pvalid[0] = 1'b0; pdata[0] = 4'h0;
    for (int k = 0; k < 12; k++) begin
      shift_en[0] = ((k % 3) == 2);
      @(negedge clk);
      chk($sformatf("pace dout[%0d]", k), dout[0], pace_exp[k / 3]);
      chk($sformatf("pace dlast[%0d]", k), dlast[0], (k / 3) == 3);
      chk($sformatf("pace pready[%0d]", k), pready[0], k == 11);
      chk($sformatf("pace busy[%0d]", k), busy[0], 1'b1);
      nxt();
    end
    shift_en[0] = 1'b0;
    @(negedge clk);
    chk("pace end busy", busy[0], 1'b0);
    nxt();

    // Reset mid-word after two bits of 4'b1111.
    pvalid[0] = 1'b1; pdata[0] = 4'b1111; shift_en[0] = 1'b1;
    nxt();
    pvalid[0] = 1'b0;
    repeat (2) nxt();
    reset = 1'b1; pvalid[0] = 1'b1; pdata[0] = 4'b0101;
    @(negedge clk);
    chk("midrst pready", pready[0], 1'b0);
    nxt();
    reset = 1'b0; pvalid[0] = 1'b0; pdata[0] = 4'h0;
    @(negedge clk);
    chk("midrst dvalid", dvalid[0], 1'b0);
    chk("midrst dout", dout[0], 1'b0);
    chk("midrst busy", busy[0], 1'b0);
    nxt();
    send(0, 4'b0101, 4'b0101, "after reset");

    // Loopback: receiver tap rx_q[3] is the wire sequence delayed by 4 cycles.
    shift_en[0] = 1'b1;
    repeat (4) nxt();
    pvalid[0] = 1'b1; pdata[0] = 4'b1011;
    nxt();
    pvalid[0] = 1'b0; pdata[0] = 4'h0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      chk($sformatf("loop rx[%0d]", t), rx_q[3], (t < 4) ? 1'b0 : loop_exp[t - 4]);
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per shift step on `dout`, with bit-valid and last-bit strobes. It is the transmit end of the serial shift-register link: its `dout` drives the `din` of the serial shift-register and receiver blocks. Supports gapless back-to-back words and a shift-enable input for pacing.

## Interface
- `WIDTH`, 4, word length in bits; legal range ≥ 2.
- `LSB_FIRST`, 1, 1 = bit 0 is transmitted first; 0 = bit WIDTH-1 is transmitted first.

- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `pdata_in`  in  WIDTH  parallel word; sampled only on handshake.
- `pvalid`  in  1  `pdata_in` is offered.
- `pready`  out  1  block can accept a word this cycle.
- `shift_en`  in  1  advance to the next bit at this edge (pacing/tick).
- `dout`  out  1  current serial bit.
- `dvalid`  out  1  `dout` carries a word bit.
- `dlast`  out  1  `dout` carries the final bit of the word.
- `busy`  out  1  word in flight (state SHIFT).

## Operation
- Internal state: FSM {IDLE, SHIFT}, WIDTH-bit shift register `sr`, bit counter `cnt` of width clog2(WIDTH).
- Handshake: a word is accepted on a rising edge where `pvalid && pready`. Nothing else samples `pdata_in`. `pvalid` is not required to hold after acceptance.
- IDLE:
  - `pready`=1, `dvalid`=0, `dlast`=0, `busy`=0, `dout`=0.
  - `shift_en` is ignored.
  - On accept: `sr`←`pdata_in`, `cnt`←0, go to SHIFT.
- SHIFT:
  - `dvalid`=1 and `busy`=1.
  - `dout` = `sr[0]` if LSB_FIRST, else `sr[WIDTH-1]`.
  - `dlast` = (`cnt`==WIDTH-1).
  - `shift_en`=0: everything holds.
  - `shift_en`=1 and `cnt`<WIDTH-1: `sr` shifts toward the output end (right if LSB_FIRST, else left), zero-filled; `cnt`++.
  - `shift_en`=1 and `cnt`==WIDTH-1: last bit is consumed and `pready`=1 in that cycle.
    - If `pvalid`: load the new word, `cnt`←0, stay in SHIFT.
    - Otherwise: go to IDLE, clear `sr`.
- `pready` = !reset && (IDLE || (SHIFT && `shift_en` && `cnt`==WIDTH-1)). This is combinational from state, `shift_en` and `reset`.
- `dout`, `dvalid`, `dlast` and `busy` are decoded from registered state only; there is no combinational path from the inputs to these outputs.

## Timing
- Reset:
  - While `reset`=1: `pready`=0; `pvalid` is ignored.
  - After the first edge with `reset`=1: state IDLE, `sr`=0, `cnt`=0, so `dout`=0, `dvalid`=0, `dlast`=0, `busy`=0.
  - `pready`=1 from the first cycle after `reset` deasserts.
- Latency: for a word accepted at edge N, bit 0 of the transmit order is on `dout` in cycle N+1.
- Each bit is held until an edge with `shift_en`=1.
- With `shift_en` tied to 1, a word occupies exactly WIDTH cycles. Back-to-back words have zero idle cycles, and `dvalid` stays high continuously.
- `dlast` is high exactly one bit-period per word. It stays high for multiple cycles if `shift_en` stalls on the last bit.
- Reset mid-word: the in-flight word is discarded with no further bits. A handshake in the same cycle as `reset` is not accepted.
- `shift_en` asserted in IDLE, or together with an accept in IDLE, has no effect. The loaded word starts at bit 0.
- Shift-register fill bits never appear on `dout` while `dvalid`=1.

## Test plan
- Reset, then single word, WIDTH=4, LSB_FIRST=1, `shift_en`=1: accept 4'b1011 at edge N -> `dout` = 1,1,0,1 in cycles N+1..N+4; `dlast` only in N+4; then `dvalid`=0, `pready`=1, `dout`=0.
- MSB-first: LSB_FIRST=0, accept 4'b1011 -> `dout` = 1,0,1,1.
- Back-to-back: `pvalid` held high with 4'b0110 then 4'b1001 -> 8 consecutive `dvalid` cycles, `dout` = 0,1,1,0,1,0,0,1; `pready` high only at acceptance cycles.
- Pacing: `shift_en` pulsed every 3rd cycle on 4'b1100 -> each bit held 3 cycles; sequence 0,0,1,1; `dlast` high for the final 3-cycle period; `pready`=0 during SHIFT except on the final shift edge.
- Reset mid-word: assert `reset` after 2 bits of 4'b1111 -> next cycle `dvalid`=0, `dout`=0, `busy`=0; `pvalid` during reset is not accepted; a new word accepted after reset transmits cleanly.
- Loopback: `dout` into a 4-stage serial shift-register receiver with `shift_en`=1 -> the receiver's output reproduces the transmitted bit sequence delayed by 4 cycles.
